// File: rtl/riscv_muldiv_arbiter.sv
// Round-robin front end sharing one iterative M-extension unit between two requesters; zero operands resolve locally.
// Fast path answers 1 cycle after accept, unit path >= 3; one op in flight, requests stall until the response is taken or flushed.
module riscv_muldiv_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_funct3,
  input  logic [31:0] req0_s1,
  input  logic [31:0] req0_s2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_funct3,
  input  logic [31:0] req1_s1,
  input  logic [31:0] req1_s2,
  input  logic        flush,
  input  logic        flush_id,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        mul_enabled,
  output logic [2:0]  mul_funct3,
  output logic [31:0] mul_s1,
  output logic [31:0] mul_s2,
  input  logic [31:0] mul_rd,
  input  logic        mul_wait
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        kill_q, kill_d;
  logic        owner_q, owner_d;
  logic        first_q, first_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] s1_q, s1_d;
  logic [31:0] s2_q, s2_d;
  logic [31:0] result_q, result_d;

  logic        grant;
  logic        accept0, accept1;
  logic        acc_id;
  logic [2:0]  acc_f3;
  logic [31:0] acc_s1, acc_s2;
  logic [31:0] fast_res;
  logic        flush_own;

  // Tie goes to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign accept0   = (state_q == IDLE) && req0_valid && !grant && !(flush && !flush_id);
  assign accept1   = (state_q == IDLE) && req1_valid &&  grant && !(flush &&  flush_id);
  assign acc_id    = accept1;
  assign acc_f3    = accept1 ? req1_funct3 : req0_funct3;
  assign acc_s1    = accept1 ? req1_s1     : req0_s1;
  assign acc_s2    = accept1 ? req1_s2     : req0_s2;
  assign flush_own = flush && (flush_id == owner_q);

  // Zero-operand results: products are 0; x/0 is all-ones, x%0 is x; 0/x and 0%x are 0.
  always_comb begin
    fast_res = 32'h0;
    if (acc_f3[2] && (acc_s2 == 32'h0)) fast_res = acc_f3[1] ? acc_s1 : 32'hFFFF_FFFF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      kill_q       <= 1'b0;
      owner_q      <= 1'b0;
      first_q      <= 1'b0;
      funct3_q     <= 3'h0;
      s1_q         <= 32'h0;
      s2_q         <= 32'h0;
      result_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      kill_q       <= kill_d;
      owner_q      <= owner_d;
      first_q      <= first_d;
      funct3_q     <= funct3_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      result_q     <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    kill_d       = kill_q;
    owner_d      = owner_q;
    first_d      = first_q;
    funct3_d     = funct3_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (accept0 || accept1) begin
          owner_d      = acc_id;
          last_grant_d = acc_id;
          funct3_d     = acc_f3;
          s1_d         = acc_s1;
          s2_d         = acc_s2;
          kill_d       = 1'b0;
          first_d      = 1'b1;
          if ((acc_s1 == 32'h0) || (acc_s2 == 32'h0)) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        // The unit cannot be aborted: a flushed op runs to completion and is then discarded.
        first_d = 1'b0;
        if (flush_own) kill_d = 1'b1;
        if (!first_q && !mul_wait) begin
          if (kill_q || flush_own) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            result_d = mul_rd;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (rsp_ready || flush_own) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = accept0;
    req1_ready  = accept1;
    rsp_valid   = (state_q == DONE);
    rsp_id      = (state_q == DONE) && owner_q;
    rsp_data    = (state_q == DONE) ? result_q : 32'h0;
    mul_enabled = (state_q == RUN);
    mul_funct3  = (state_q == RUN) ? funct3_q : 3'h0;
    mul_s1      = (state_q == RUN) ? s1_q : 32'h0;
    mul_s2      = (state_q == RUN) ? s2_q : 32'h0;
  end

endmodule

// File: tb/tb_riscv_muldiv_arbiter.sv
// Directed bench for riscv_muldiv_arbiter with a behavioural iterative M unit of programmable latency.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_riscv_muldiv_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [31:0] req0_s1, req0_s2, req1_s1, req1_s2;
  logic        flush, flush_id;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        mul_enabled, mul_wait;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_s1, mul_s2, mul_rd;

  int checks = 0;
  int errors = 0;

  riscv_muldiv_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
    .req0_s1(req0_s1), .req0_s2(req0_s2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct3(req1_funct3),
    .req1_s1(req1_s1), .req1_s2(req1_s2),
    .flush(flush), .flush_id(flush_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mul_enabled(mul_enabled), .mul_funct3(mul_funct3), .mul_s1(mul_s1), .mul_s2(mul_s2),
    .mul_rd(mul_rd), .mul_wait(mul_wait)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Behavioural unit: busy for unit_lat cycles after enable, result valid once wait drops.
  int unit_lat = 2;
  int unit_cnt;

  function automatic logic [31:0] unit_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'h0;
    unit_calc = 32'h0;
    case (f)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; unit_calc = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; unit_calc = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; unit_calc = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; unit_calc = p[63:32]; end
      3'd4: if (b == 32'h0) unit_calc = 32'h0;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) unit_calc = a;
            else unit_calc = $signed(a) / $signed(b);
      3'd5: if (b != 32'h0) unit_calc = a / b;
      3'd6: if (b == 32'h0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) unit_calc = 32'h0;
            else unit_calc = $signed(a) % $signed(b);
      default: if (b != 32'h0) unit_calc = a % b;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset)            unit_cnt <= 0;
    else if (mul_enabled) unit_cnt <= unit_cnt + 1;
    else                  unit_cnt <= 0;
  end
  assign mul_wait = mul_enabled && (unit_cnt < unit_lat);
  assign mul_rd   = mul_wait ? 32'h0 : unit_calc(mul_funct3, mul_s1, mul_s2);

  // Counts enabled cycles and any operand change while the unit is running.
  int          en_seen = 0;
  int          unstable = 0;
  logic        prev_en = 1'b0;
  logic [66:0] prev_ops = '0;
  always @(negedge clock) begin
    if (mul_enabled) begin
      en_seen++;
      if (prev_en && ({mul_funct3, mul_s1, mul_s2} !== prev_ops)) unstable++;
    end
    prev_en  = mul_enabled;
    prev_ops = {mul_funct3, mul_s1, mul_s2};
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    if (id) begin req1_valid = 1'b1; req1_funct3 = f; req1_s1 = a; req1_s2 = b; end
    else    begin req0_valid = 1'b1; req0_funct3 = f; req0_s1 = a; req0_s2 = b; end
    waited = 0;
    @(negedge clock);
    while (!(id ? req1_ready : req0_ready) && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge clock);
    while (!rsp_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_outputs(input string tag);
    check(tag, {22'h0, req0_ready, req1_ready, rsp_valid, rsp_id, mul_enabled, mul_funct3, 2'b0}, 32'h0);
    check(tag, rsp_data | mul_s1 | mul_s2, 32'h0);
  endtask

  logic        t_id  [4];
  logic [2:0]  t_f3  [4];
  logic [31:0] t_a   [4];
  logic [31:0] t_b   [4];
  logic [31:0] t_exp [4];

  initial begin
    int w, lat, ng, nr, rsp_seen;
    logic fell_en;
    logic        g  [4];
    logic        rid[4];
    logic [31:0] rdt[4];

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_funct3 = 3'h0; req1_funct3 = 3'h0;
    req0_s1 = 32'h0; req0_s2 = 32'h0; req1_s1 = 32'h0; req1_s2 = 32'h0;
    flush = 1'b0; flush_id = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 idle_outputs("reset_outs");
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    idle_outputs("idle_outs");

    // mul 3*5 on requester 0 through the unit
    unit_lat = 2; en_seen = 0; unstable = 0;
    issue(1'b0, 3'd0, 32'd3, 32'd5, w);
    check("mul_ready_first", 32'(w), 32'd0);
    check("mul_en_run", 32'(mul_enabled), 32'd1);
    check("mul_ops_run", {mul_s1[15:0], mul_s2[15:0]}, {16'd3, 16'd5});
    wait_rsp(lat);
    check("mul_data", rsp_data, 32'd15);
    check("mul_id", 32'(rsp_id), 32'd0);
    check("mul_lat", 32'(lat), 32'd4);
    @(posedge clock); #1;
    check("mul_stable", 32'(unstable), 32'd0);
    check("mul_en_cycles", 32'(en_seen), 32'd3);

    // Flush of a requester only blocks that requester's ready
    req0_valid = 1'b1; flush = 1'b1; flush_id = 1'b0;
    #1 check("flush_blocks_ready", 32'(req0_ready), 32'd0);
    flush_id = 1'b1;
    #1 check("flush_other_ready", 32'(req0_ready), 32'd1);
    req0_valid = 1'b0; flush = 1'b0; flush_id = 1'b0;

    // Minimum unit latency, mulhu on requester 1
    unit_lat = 1;
    issue(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
    wait_rsp(lat);
    check("mulhu_data", rsp_data, 32'hFFFF_FFFE);
    check("mulhu_id", 32'(rsp_id), 32'd1);
    check("min_lat", 32'(lat), 32'd3);
    @(posedge clock); #1;

    // Round-robin with both requesters always valid, starting from reset
    reset = 1'b1; #1 reset = 1'b0;
    @(posedge clock); #1;
    unit_lat = 2;
    req0_funct3 = 3'd4; req0_s1 = 32'd100; req0_s2 = 32'd7;
    req1_funct3 = 3'd7; req1_s1 = 32'd100; req1_s2 = 32'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0; nr = 0;
    for (int i = 0; i < 300 && nr < 4; i++) begin
      @(negedge clock);
      if (req0_ready && ng < 4) begin g[ng] = 1'b0; ng++; end
      if (req1_ready && ng < 4) begin g[ng] = 1'b1; ng++; end
      if (rsp_valid && nr < 4) begin rid[nr] = rsp_id; rdt[nr] = rsp_data; nr++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_rsp_count", 32'(nr), 32'd4);
    check("rr_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < nr && i < ng; i++) begin
      check("rr_grant", 32'(g[i]), 32'(i % 2));
      check("rr_rsp_id", 32'(rid[i]), 32'(i % 2));
      check("rr_rsp_data", rdt[i], (i % 2 == 0) ? 32'd14 : 32'd2);
    end
    @(posedge clock); #1;

    // Zero-operand fast path: answer next cycle, unit untouched
    t_id[0] = 1'b0; t_f3[0] = 3'd5; t_a[0] = 32'd5;          t_b[0] = 32'd0;      t_exp[0] = 32'hFFFF_FFFF;
    t_id[1] = 1'b1; t_f3[1] = 3'd6; t_a[1] = 32'hFFFF_FFF9; t_b[1] = 32'd0;      t_exp[1] = 32'hFFFF_FFF9;
    t_id[2] = 1'b0; t_f3[2] = 3'd1; t_a[2] = 32'd0;          t_b[2] = 32'h1234;   t_exp[2] = 32'h0;
    t_id[3] = 1'b1; t_f3[3] = 3'd4; t_a[3] = 32'd0;          t_b[3] = 32'd7;      t_exp[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      en_seen = 0;
      issue(t_id[i], t_f3[i], t_a[i], t_b[i], w);
      wait_rsp(lat);
      check("zero_data", rsp_data, t_exp[i]);
      check("zero_id", 32'(rsp_id), 32'(t_id[i]));
      check("zero_lat", 32'(lat), 32'd1);
      @(posedge clock); #1;
      check("zero_no_unit", 32'(en_seen), 32'd0);
    end

    // Signed corner cases through the unit
    unit_lat = 3;
    t_id[0] = 1'b0; t_f3[0] = 3'd4; t_a[0] = 32'h8000_0000; t_b[0] = 32'hFFFF_FFFF; t_exp[0] = 32'h8000_0000;
    t_id[1] = 1'b1; t_f3[1] = 3'd6; t_a[1] = 32'h8000_0000; t_b[1] = 32'hFFFF_FFFF; t_exp[1] = 32'h0;
    t_id[2] = 1'b0; t_f3[2] = 3'd2; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'd2;          t_exp[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      issue(t_id[i], t_f3[i], t_a[i], t_b[i], w);
      wait_rsp(lat);
      check("signed_data", rsp_data, t_exp[i]);
      check("signed_id", 32'(rsp_id), 32'(t_id[i]));
      @(posedge clock); #1;
    end

    // Response backpressure: DONE holds everything for 10 cycles
    rsp_ready = 1'b0;
    issue(1'b1, 3'd0, 32'd6, 32'd7, w);
    wait_rsp(lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_data", rsp_data, 32'd42);
      check("bp_id_valid", {30'h0, rsp_id, rsp_valid}, 32'h3);
      check("bp_ready_en", {29'h0, req0_ready, req1_ready, mul_enabled}, 32'h0);
      @(negedge clock);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release", 32'(rsp_valid), 32'd0);

    // Owner flush mid-RUN: unit runs out, no response, then a new op goes through
    unit_lat = 5; en_seen = 0;
    issue(1'b0, 3'd0, 32'd2, 32'd3, w);
    flush = 1'b1; flush_id = 1'b0;
    @(posedge clock); #1 flush = 1'b0;
    rsp_seen = 0; fell_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) rsp_seen++;
      if (mul_enabled && !mul_wait) fell_en = 1'b1;
    end
    check("kill_no_rsp", 32'(rsp_seen), 32'd0);
    check("kill_en_held", 32'(fell_en), 32'd1);
    check("kill_en_cycles", 32'(en_seen), 32'd6);
    @(posedge clock); #1;
    unit_lat = 1;
    issue(1'b1, 3'd0, 32'd4, 32'd5, w);
    wait_rsp(lat);
    check("after_kill_data", rsp_data, 32'd20);
    check("after_kill_id", 32'(rsp_id), 32'd1);
    @(posedge clock); #1;

    // Flush in DONE: other requester's flush ignored, owner's flush drops the response
    rsp_ready = 1'b0;
    issue(1'b0, 3'd5, 32'd100, 32'd7, w);
    wait_rsp(lat);
    check("done_flush_data", rsp_data, 32'd14);
    flush = 1'b1; flush_id = 1'b1;
    @(posedge clock); #1;
    check("done_flush_other", 32'(rsp_valid), 32'd1);
    flush_id = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    check("done_flush_drop", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b1;

    // Asynchronous reset mid-RUN
    unit_lat = 5;
    issue(1'b1, 3'd0, 32'd9, 32'd9, w);
    check("rst_run_en", 32'(mul_enabled), 32'd1);
    #2 reset = 1'b1;
    #1 idle_outputs("rst_async");
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    unit_lat = 1;
    issue(1'b0, 3'd0, 32'd7, 32'd8, w);
    check("rst_recover_grant", 32'(w), 32'd0);
    wait_rsp(lat);
    check("rst_recover_data", rsp_data, 32'd56);
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
